// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, register map and FSM encoding for irq_ctrl
package irq_pkg;

  localparam int IRQ_N_SRC = 4;
  localparam int IRQ_ID_W  = 2;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CAUSE   = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  // Fixed priority: bit 0 wins, so scan downward and let the lowest set bit overwrite.
  function automatic logic [IRQ_ID_W-1:0] lowest_idx(input logic [31:0] v);
    logic [IRQ_ID_W-1:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = IRQ_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchronizer plus rising-edge detect for one interrupt line
module irq_sync_edge (
  input  logic Clk_CPU,
  input  logic rst,
  input  logic i_src,
  output logic o_edge
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [1:0] r_arm;

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_arm   <= 2'd0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_arm != 2'd3) r_arm <= r_arm + 2'd1;
    end
  end

  // A line already high out of reset must not look like an edge while prev fills.
  assign o_edge = r_sync2 & ~r_prev & (r_arm == 2'd3);

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritized interrupt controller with Ireq/Iack handshake to the CPU
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = IRQ_N_SRC
) (
  input  logic                Clk_CPU,
  input  logic                rst,
  input  logic [N_SRC-1:0]    irq_src,
  input  logic                reg_we,
  input  logic [1:0]          reg_addr,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  output logic                Ireq,
  input  logic                Iack,
  output logic [IRQ_ID_W-1:0] irq_id
);

  logic [N_SRC-1:0]    w_edge;
  logic [N_SRC-1:0]    w_w1c;
  logic [N_SRC-1:0]    w_ack_clr;
  logic [N_SRC-1:0]    w_active;
  logic                w_wr_pend;
  logic                w_wr_mask;
  logic                w_wr_ctrl;
  logic                w_abort;
  logic                w_unused_wdata;

  logic [N_SRC-1:0]    r_pending;
  logic [N_SRC-1:0]    r_mask;
  logic                r_en;
  logic [1:0]          r_state;
  logic                r_ireq;
  logic [IRQ_ID_W-1:0] r_irq_id;

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_src
      irq_sync_edge u_sync (
        .Clk_CPU (Clk_CPU),
        .rst     (rst),
        .i_src   (irq_src[g]),
        .o_edge  (w_edge[g])
      );
    end
  endgenerate

  assign w_wr_pend = reg_we && (reg_addr == ADDR_PENDING);
  assign w_wr_mask = reg_we && (reg_addr == ADDR_MASK);
  assign w_wr_ctrl = reg_we && (reg_addr == ADDR_CTRL);
  assign w_abort   = w_wr_ctrl && reg_wdata[CTRL_ABORT_BIT];
  assign w_active  = r_pending & r_mask;
  assign w_w1c     = w_wr_pend ? reg_wdata[N_SRC-1:0] : '0;
  // An abort in the same cycle as Iack leaves PENDING untouched.
  assign w_ack_clr = (r_state == ST_REQ && Iack && !w_abort) ? (N_SRC'(1) << r_irq_id) : '0;
  assign w_unused_wdata = ^reg_wdata[31:N_SRC];

  always_ff @(posedge Clk_CPU or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_en      <= 1'b0;
      r_state   <= ST_IDLE;
      r_ireq    <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      // New edges override any clear of the same bit.
      r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_edge;
      if (w_wr_mask) r_mask <= reg_wdata[N_SRC-1:0];
      if (w_wr_ctrl) r_en <= reg_wdata[CTRL_EN_BIT];
      case (r_state)
        ST_IDLE: begin
          if (r_en && |w_active) begin
            r_irq_id <= lowest_idx(32'(w_active));
            r_ireq   <= 1'b1;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_abort) begin
            r_ireq  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (Iack) begin
            r_ireq  <= 1'b0;
            r_state <= ST_SERV;
          end
        end
        ST_SERV: begin
          if (w_abort || !Iack) r_state <= ST_IDLE;
        end
        default: begin
          r_ireq  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_PENDING: reg_rdata[N_SRC-1:0]    = r_pending;
      ADDR_MASK:    reg_rdata[N_SRC-1:0]    = r_mask;
      ADDR_CAUSE:   reg_rdata[IRQ_ID_W:0]   = {r_ireq, r_irq_id};
      default:      reg_rdata[CTRL_EN_BIT]  = r_en;
    endcase
  end

  assign Ireq   = r_ireq;
  assign irq_id = r_irq_id;

endmodule
